// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: DX instruction info in, stall/forward selects out.
// Perf-counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_if #(
   parameter int unsigned AW = 5
);
   logic          freeze;
   logic          e_valid;
   logic [AW-1:0] e_rs_addr;
   logic [AW-1:0] e_rt_addr;
   logic          e_uses_rs;
   logic          e_uses_rt;
   logic          e_wr_en;
   logic [AW-1:0] e_wr_addr;
   logic          e_is_load;
   logic          e_is_md;
   logic          stall;
   logic          fwdX_rs;
   logic          fwdX_rt;
   logic          fwdM_rs;
   logic          fwdM_rt;
   logic          md_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   loaduse_events;
`endif

   modport master (
      output freeze, e_valid, e_rs_addr, e_rt_addr, e_uses_rs, e_uses_rt,
             e_wr_en, e_wr_addr, e_is_load, e_is_md,
`ifdef HAZ_PERF_CNT_EN
      input  stall_cycles, loaduse_events,
`endif
      input  stall, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, md_busy
   );

   modport slave (
      input  freeze, e_valid, e_rs_addr, e_rt_addr, e_uses_rs, e_uses_rt,
             e_wr_en, e_wr_addr, e_is_load, e_is_md,
`ifdef HAZ_PERF_CNT_EN
      output stall_cycles, loaduse_events,
`endif
      output stall, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, md_busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection and forwarding control: X/M destination scoreboard, load-use
// stall and mul/div sequencing. Optional stall/load-use counters: HAZ_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int unsigned MD_LATENCY = 4,
   parameter int unsigned AW         = 5
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hif
);
   localparam int unsigned CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_INIT = CW'(MD_LATENCY - 1);

   typedef struct packed {
      logic          valid;
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic          is_load;
   } slot_t;

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   slot_t         x_slot, m_slot, dx_slot;
   logic          match_x_rs, match_x_rt, match_m_rs, match_m_rt;
   logic          loaduse, busy_st, md_issue, stall_int, quiet;

   function automatic logic src_match(input slot_t s, input logic v, input logic u,
                                      input logic [AW-1:0] a);
      return v & u & s.valid & s.wr_en & (s.wr_addr == a) & (a != '0);
   endfunction

   always_comb begin
      dx_slot         = '0;
      dx_slot.valid   = hif.e_valid;
      dx_slot.wr_en   = hif.e_wr_en;
      dx_slot.wr_addr = hif.e_wr_addr;
      dx_slot.is_load = hif.e_is_load;
   end

   assign match_x_rs = src_match(x_slot, hif.e_valid, hif.e_uses_rs, hif.e_rs_addr);
   assign match_x_rt = src_match(x_slot, hif.e_valid, hif.e_uses_rt, hif.e_rt_addr);
   assign match_m_rs = src_match(m_slot, hif.e_valid, hif.e_uses_rs, hif.e_rs_addr);
   assign match_m_rt = src_match(m_slot, hif.e_valid, hif.e_uses_rt, hif.e_rt_addr);

   assign loaduse   = (match_x_rs | match_x_rt) & x_slot.is_load;
   assign busy_st   = (state == MD_BUSY);
   assign stall_int = (loaduse | busy_st) & ~hif.freeze;
   assign md_issue  = ~busy_st & hif.e_valid & hif.e_is_md & ~loaduse & ~hif.freeze;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: freeze holds both the state and the occupancy counter
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!hif.freeze) begin
         unique case (state)
            IDLE: begin
               if (md_issue) begin
                  state_nxt = MD_BUSY;
                  cnt_nxt   = CNT_INIT;
               end
            end
            MD_BUSY: begin
               cnt_nxt = cnt - CNT_ONE;
               if (cnt == CNT_ONE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs
   always_comb begin
      quiet       = hif.freeze | loaduse | busy_st;
      hif.stall   = stall_int;
      hif.md_busy = busy_st & ~hif.freeze;
      hif.fwdX_rs = ~quiet & match_x_rs & ~x_slot.is_load;
      hif.fwdX_rt = ~quiet & match_x_rt & ~x_slot.is_load;
      hif.fwdM_rs = ~quiet & match_m_rs & ~(match_x_rs & ~x_slot.is_load);
      hif.fwdM_rt = ~quiet & match_m_rt & ~(match_x_rt & ~x_slot.is_load);
   end

   // Scoreboard: mul/div keeps X occupied and drains M; load-use bubbles X
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_slot <= '0;
         m_slot <= '0;
      end else if (!hif.freeze) begin
         if (busy_st) begin
            m_slot <= '0;
         end else if (loaduse) begin
            x_slot <= '0;
            m_slot <= x_slot;
         end else begin
            x_slot <= dx_slot;
            m_slot <= x_slot;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_q, loaduse_events_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q   <= '0;
         loaduse_events_q <= '0;
      end else if (!hif.freeze) begin
         if (stall_int && stall_cycles_q != '1)
            stall_cycles_q <= stall_cycles_q + 32'd1;
         if (loaduse && loaduse_events_q != '1)
            loaduse_events_q <= loaduse_events_q + 32'd1;
      end
   end

   assign hif.stall_cycles   = stall_cycles_q;
   assign hif.loaduse_events = loaduse_events_q;
`endif
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard detection and forwarding controller for the 5-stage pipeline. Drives the stall and forwarding selects that feed the DX-to-X forwarding mux.
- Keeps its own registered scoreboard of the destinations of the instructions in the X and M slots. Detects load-use hazards and sequences the multi-cycle multiply/divide unit.
- Sits between the DX pipeline register and the X stage.

Parameters:
- MD_LATENCY, 4: cycles the mul/div unit occupies X (legal range 2..16).
- AW, 5: register address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  global pipeline freeze (memory wait); holds all state
- e_valid  in  1  DX register holds a real instruction
- e_rs_addr  in  AW  source rs of the DX instruction
- e_rt_addr  in  AW  source rt of the DX instruction
- e_uses_rs  in  1  DX instruction reads rs
- e_uses_rt  in  1  DX instruction reads rt
- e_wr_en  in  1  DX instruction writes a register
- e_wr_addr  in  AW  DX instruction destination
- e_is_load  in  1  DX instruction is a load
- e_is_md  in  1  DX instruction is mul/div
- stall  out  1  hold DX and insert a bubble into X
- fwdX_rs, fwdX_rt  out  1 each  select X-stage result for rs/rt
- fwdM_rs, fwdM_rt  out  1 each  select M-stage result for rs/rt
- md_busy  out  1  mul/div unit hold; X-stage register keeps its contents

Behaviour:
- Scoreboard: two slots, X and M, each holding {valid, wr_en, wr_addr, is_load}. Reset clears both slots to all-zero.
- Advance rule (rising edge, freeze=0):
  - Not stalled and not md_busy: X <= DX instruction info, M <= X.
  - stall=1: X <= bubble (all zero), M <= X.
  - md_busy=1: X holds, M <= bubble.
  - freeze=1: everything holds, including the FSM and counter.
- Match definitions:
  - matchX_rs = e_valid & e_uses_rs & X.valid & X.wr_en & (X.wr_addr == e_rs_addr) & (e_rs_addr != 0). matchX_rt likewise on rt.
  - matchM_* is defined the same way against slot M.
- Forwarding (combinational):
  - fwdX_rs = matchX_rs & ~X.is_load.
  - fwdM_rs = matchM_rs & ~fwdX_rs. X has priority over M.
  - rt is handled identically.
  - All forwarding outputs are 0 when stall, md_busy or freeze is asserted.
- Load-use: loaduse = (matchX_rs | matchX_rt) & X.is_load. This gives exactly 1 stall cycle. Next cycle the load sits in M and fwdM is asserted.
- FSM states: IDLE, MD_BUSY.
  - IDLE -> MD_BUSY when e_valid & e_is_md & ~loaduse & ~freeze. The mul/div issues into X that edge. cnt <= MD_LATENCY-1.
  - MD_BUSY: md_busy=1 and stall=1. cnt decrements each unfrozen cycle. At cnt==1 the next edge returns to IDLE, and X is then treated as a normal completed instruction (forwardable).
  - A back-to-back mul/div in DX while in MD_BUSY waits. It issues on the cycle after the return to IDLE.
- stall = (loaduse | state==MD_BUSY) & ~freeze.
- md_busy = state==MD_BUSY & ~freeze.
- Simultaneous events:
  - freeze dominates everything.
  - loaduse with e_is_md: the load-use stall is taken first, and the mul/div issues the following cycle.
- Reset values:
  - Outputs: stall=0, fwd*=0, md_busy=0.
  - State: IDLE, cnt=0, slots cleared.
  - Reset mid-MD_BUSY aborts to IDLE immediately (asynchronous).
- Register 0 is never forwarded and never causes a stall.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles (32 bits) and loaduse_events (32 bits).
  - stall_cycles increments every cycle stall=1. loaduse_events increments on each cycle loaduse causes a stall.
  - Both saturate at 0xFFFFFFFF, hold during freeze, and clear on rst.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- add r3 in X, DX reads r3 as rs -> fwdX_rs=1, stall=0. Next cycle, with add in M and a new reader of r3 -> fwdM_rs=1, fwdX_rs=0.
- lw r5 in X, DX uses r5 as rt -> stall=1 for exactly 1 cycle, then fwdM_rt=1. With HAZ_PERF_CNT_EN: loaduse_events=1 and stall_cycles=1.
- r3 written by both X and M slots, DX reads r3 -> fwdX_rs=1, fwdM_rs=0. DX reads r0 with r0 in X -> no forwarding, no stall.
- mul r7 issued with MD_LATENCY=4 -> stall=md_busy=1 for 3 cycles. Dependent reader of r7 then gets fwdX=1. A second mul queued behind issues 1 cycle later.
- freeze=1 for 5 cycles mid-MD_BUSY (cnt=2) -> cnt, slots and outputs held, stall=0. On release the remaining 2 busy cycles complete.
- rst asserted in MD_BUSY -> md_busy=0 and stall=0 immediately without a clock edge. Slots are empty afterwards, so no forwarding occurs.
